// File: rtl/mem_responder.sv
// Purpose: storage endpoint for the valid/ready single-port memory bus. Internal array mem, optional parity (macro PARITY_EN).
// Latency: a request captured at edge N gives a one-cycle ready in the cycle after edge N+LATENCY; back-to-back costs LATENCY+2.
// Backpressure: one request at a time; valid is ignored outside IDLE and captured values are used for the whole transfer.
module mem_responder #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  valid,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  ready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  capture;
  logic                  enter_resp;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic                  err_q;

  // Request seen by the memory action: with LATENCY=0 the action happens on the capture edge itself
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  acc_wr;
  logic [WIDTH-1:0]      acc_wdata;
  logic                  acc_in_range;
  logic [WIDTH-1:0]      rd_word;
  logic                  resp_err;

  logic [WIDTH-1:0]      mem [DEPTH];

`ifdef PARITY_EN
  logic [DEPTH-1:0]      par_mem;
`endif

  // Next-state and output decode; enter_resp marks the edge that performs the memory action
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    capture    = 1'b0;
    enter_resp = 1'b0;
    ready      = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          capture = 1'b1;
          cnt_nxt = 4'(LATENCY);
          if (LATENCY > 0) begin
            state_nxt = WAIT;
          end else begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        ready     = 1'b1;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Select live inputs on the capture edge, captured values otherwise, and form the response
  always_comb begin
    acc_addr     = capture ? addr  : addr_q;
    acc_wr       = capture ? wr_rd : wr_q;
    acc_wdata    = capture ? wdata : wdata_q;
    acc_in_range = int'(acc_addr) < DEPTH;
    rd_word      = acc_in_range ? mem[acc_addr] : '0;
`ifdef PARITY_EN
    resp_err     = !acc_in_range || (!acc_wr && ((^rd_word) != par_mem[acc_addr]));
`else
    resp_err     = !acc_in_range;
`endif
  end

  // State register and wait counter
  always_ff @(posedge clk) begin
    if (res) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Hold the accepted request for the whole transfer
  always_ff @(posedge clk) begin
    if (res) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else if (capture) begin
      addr_q  <= addr;
      wr_q    <= wr_rd;
      wdata_q <= wdata;
    end
  end

  // Response registers: rdata only changes on reads, err is latched for the RESP cycle
  always_ff @(posedge clk) begin
    if (res) begin
      rdata <= '0;
      err_q <= 1'b0;
    end else if (enter_resp) begin
      err_q <= resp_err;
      if (!acc_wr) begin
        rdata <= rd_word;
      end
    end
  end

  // Storage array; not reset so backdoor loads survive reset, and reset aborts pending writes
  always_ff @(posedge clk) begin
    if (!res && enter_resp && acc_wr && acc_in_range) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

`ifdef PARITY_EN
  // Parity shadow: cleared on reset so every word starts out as even parity
  always_ff @(posedge clk) begin
    if (res) begin
      par_mem <= '0;
    end else if (enter_resp && acc_wr && acc_in_range) begin
      par_mem[acc_addr] <= ^acc_wdata;
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table on a DEPTH=32 instance plus
// hand-written sequences for the full sweep, out-of-range (DEPTH=24) and reset-in-WAIT cases.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       res;
  logic       valid_a, valid_b;
  logic       wr_rd;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic       ready_a, err_a, ready_b, err_b;
  logic [7:0] rdata_a, rdata_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_responder #(.WIDTH(8), .DEPTH(32), .LATENCY(2)) dut (
    .clk(clk), .res(res), .valid(valid_a), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
    .ready(ready_a), .rdata(rdata_a), .err(err_a)
  );

  mem_responder #(.WIDTH(8), .DEPTH(24), .LATENCY(2)) dut24 (
    .clk(clk), .res(res), .valid(valid_b), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
    .ready(ready_b), .rdata(rdata_b), .err(err_b)
  );

  typedef struct {
    bit         b2b;
    bit         wr;
    logic [4:0] a;
    logic [7:0] d;
    logic [7:0] exp_rd;
    bit         exp_err;
    int         exp_cyc;
  } vec_t;

  vec_t vt[12];
  logic [7:0] model[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one request to instance sel (0 = DEPTH 32, 1 = DEPTH 24), hold valid until ready.
  // cyc counts edges from the drive point until ready is observed.
  task automatic xfer(input bit sel, input bit wr, input logic [4:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic e, output int cyc);
    bit seen;
    seen    = 1'b0;
    wr_rd   = wr;
    addr    = a;
    wdata   = d;
    valid_a = !sel;
    valid_b = sel;
    cyc     = 0;
    rd      = 'x;
    e       = 'x;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if ((sel ? ready_b : ready_a) === 1'b1) begin
        seen = 1'b1;
        rd   = sel ? rdata_b : rdata_a;
        e    = sel ? err_b : err_a;
      end
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL xfer_timeout: no ready within %0d cycles for addr %0h", cyc, a);
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic       e;
    int         cyc;
    int         pulses;

    // LATENCY=2 single write then read of word 15
    vt[0] = '{1'b0, 1'b1, 5'd15, 8'hA5, 8'h00, 1'b0, 3};
    vt[1] = '{1'b0, 1'b0, 5'd15, 8'h00, 8'hA5, 1'b0, 3};
    // Back-to-back writes 3..7 then reads 3..7; writes leave rdata at A5
    for (int i = 0; i < 5; i++) begin
      vt[2 + i] = '{(i != 0), 1'b1, 5'(3 + i), 8'(16 + i), 8'hA5, 1'b0, (i == 0) ? 3 : 4};
      vt[7 + i] = '{1'b1, 1'b0, 5'(3 + i), 8'h00, 8'(16 + i), 1'b0, 4};
    end

    res     = 1'b1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    wr_rd   = 1'b0;
    addr    = '0;
    wdata   = '0;
    repeat (3) @(posedge clk);
    #1;
    res = 1'b0;
    check("rst_ready", ready_a, 0);
    check("rst_rdata", rdata_a, 0);
    check("rst_err", err_a, 0);
    check("rst_ready24", ready_b, 0);

    // Vector table
    for (int i = 0; i < 12; i++) begin
      if (!vt[i].b2b) idle(1);
      xfer(1'b0, vt[i].wr, vt[i].a, vt[i].d, rd, e, cyc);
      check($sformatf("vec%0d_latency", i), cyc, vt[i].exp_cyc);
      check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      check($sformatf("vec%0d_err", i), e, vt[i].exp_err);
    end

    // Full sweep: random writes to every word, then read all back
    idle(1);
    for (int i = 0; i < 32; i++) begin
      model[i] = 8'($urandom);
      xfer(1'b0, 1'b1, 5'(i), model[i], rd, e, cyc);
    end
    for (int i = 0; i < 32; i++) begin
      xfer(1'b0, 1'b0, 5'(i), 8'h00, rd, e, cyc);
      check($sformatf("sweep_rd%0d", i), rd, model[i]);
      check($sformatf("sweep_err%0d", i), e, 0);
      check($sformatf("sweep_mem%0d", i), dut.mem[i], model[i]);
    end

    // DEPTH=24: normal access near the top, then out-of-range write/read
    idle(1);
    xfer(1'b1, 1'b1, 5'd1, 8'h11, rd, e, cyc);
    check("d24_wr1_err", e, 0);
    idle(1);
    xfer(1'b1, 1'b1, 5'd23, 8'h77, rd, e, cyc);
    check("d24_wr23_err", e, 0);
    idle(1);
    xfer(1'b1, 1'b1, 5'd25, 8'hFF, rd, e, cyc);
    check("d24_wr25_latency", cyc, 3);
    check("d24_wr25_err", e, 1);
    idle(1);
    xfer(1'b1, 1'b0, 5'd1, 8'h00, rd, e, cyc);
    check("d24_rd1_noalias", rd, 8'h11);
    check("d24_rd1_err", e, 0);
    idle(1);
    xfer(1'b1, 1'b0, 5'd23, 8'h00, rd, e, cyc);
    check("d24_rd23", rd, 8'h77);
    idle(1);
    xfer(1'b1, 1'b0, 5'd25, 8'h00, rd, e, cyc);
    check("d24_rd25_rdata", rd, 8'h00);
    check("d24_rd25_err", e, 1);
    idle(1);
    check("d24_err_idle", err_b, 0);

    // Reset during WAIT of a write to word 9 (old value 33)
    idle(1);
    xfer(1'b0, 1'b1, 5'd9, 8'h33, rd, e, cyc);
    idle(1);
    xfer(1'b0, 1'b0, 5'd9, 8'h00, rd, e, cyc);
    check("rstwait_pre_rd", rd, 8'h33);
    idle(1);
    wr_rd   = 1'b1;
    addr    = 5'd9;
    wdata   = 8'hCC;
    valid_a = 1'b1;
    @(posedge clk);
    #1;
    res     = 1'b1;
    valid_a = 1'b0;
    @(posedge clk);
    #1;
    check("rstwait_ready", ready_a, 0);
    check("rstwait_rdata", rdata_a, 0);
    res    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (ready_a === 1'b1) pulses++;
    end
    check("rstwait_no_ready", pulses, 0);
    xfer(1'b0, 1'b0, 5'd9, 8'h00, rd, e, cyc);
    check("rstwait_rd9", rd, 8'h33);
    check("rstwait_rd9_latency", cyc, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
